// File: rtl/serial_frame_source.sv
// serial_frame_source
//   Parallel-to-serial frame feeder for the Moore sequence detector. A word
//   accepted on the din_valid/din_ready handshake is shifted out MSB-first on
//   x, one bit per clk. x_last flags the final bit of each frame, and frames
//   counts completed frames modulo 256.
//
//   Optional feature macro: SERIAL_FRAME_PARITY_EN
//     defined   - each frame gets a trailing even-parity bit (PAR state);
//                 x_last marks the parity bit.
//     undefined - frames are WIDTH bits long; x_last marks the LSB.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-low reset
//   din        in   [WIDTH-1:0] parallel word to send
//   din_valid  in   din is offered this cycle
//   din_ready  out  word is accepted at this rising edge (state decode only)
//   x          out  serial bit to the detector
//   x_valid    out  x carries a frame bit
//   x_last     out  x carries the final bit of the frame
//   frames     out  [7:0] completed-frame count, wrapping

module serial_frame_source #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             x_last,
    output logic [7:0]       frames
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_ZERO = CW'(0);

`ifdef SERIAL_FRAME_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    state_t           state_r;
    logic [WIDTH-1:0] shreg_r;
    logic [CW-1:0]    cnt_r;
`ifdef SERIAL_FRAME_PARITY_EN
    logic             par_r;
`endif
    logic [7:0]       frames_r;
    logic             xfer_s;

    assign frames = frames_r;
    assign xfer_s = din_valid & din_ready;

    // Output decode from registered state; din_ready never looks at din_valid.
    always_comb begin
        x         = 1'b0;
        x_valid   = 1'b0;
        x_last    = 1'b0;
        din_ready = 1'b0;
        case (state_r)
            IDLE: begin
                din_ready = 1'b1;
            end
            SHIFT: begin
                x       = shreg_r[WIDTH-1];
                x_valid = 1'b1;
`ifndef SERIAL_FRAME_PARITY_EN
                // Without parity the LSB is the last bit, so the next word
                // may be accepted on the edge that ends it.
                if (cnt_r == CNT_ZERO) begin
                    x_last    = 1'b1;
                    din_ready = 1'b1;
                end else begin
                    x_last    = 1'b0;
                    din_ready = 1'b0;
                end
`endif
            end
`ifdef SERIAL_FRAME_PARITY_EN
            PAR: begin
                x         = par_r;
                x_valid   = 1'b1;
                x_last    = 1'b1;
                din_ready = 1'b1;
            end
`endif
            default: begin
                x         = 1'b0;
                x_valid   = 1'b0;
                x_last    = 1'b0;
                din_ready = 1'b0;
            end
        endcase
    end

    // Frame FSM: shift, parity accumulate, frame count and word reload.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= IDLE;
            shreg_r  <= '0;
            cnt_r    <= CNT_ZERO;
`ifdef SERIAL_FRAME_PARITY_EN
            par_r    <= 1'b0;
`endif
            frames_r <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r <= IDLE;
                end
                SHIFT: begin
                    shreg_r <= shreg_r << 1;
`ifdef SERIAL_FRAME_PARITY_EN
                    par_r   <= par_r ^ shreg_r[WIDTH-1];
`endif
                    cnt_r   <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ZERO) begin
`ifdef SERIAL_FRAME_PARITY_EN
                        state_r  <= PAR;
`else
                        frames_r <= frames_r + 8'd1;
                        state_r  <= IDLE;
`endif
                    end else begin
                        state_r <= SHIFT;
                    end
                end
`ifdef SERIAL_FRAME_PARITY_EN
                PAR: begin
                    frames_r <= frames_r + 8'd1;
                    state_r  <= IDLE;
                end
`endif
                default: begin
                    state_r <= IDLE;
                end
            endcase
            // A transfer can only happen in IDLE or on the last bit; the
            // reload overrides the shift/idle updates above.
            if (xfer_s) begin
                shreg_r <= din;
                cnt_r   <= CNT_LOAD;
`ifdef SERIAL_FRAME_PARITY_EN
                par_r   <= 1'b0;
`endif
                state_r <= SHIFT;
            end else begin
                shreg_r <= shreg_r << 1;
                if (state_r == IDLE) begin
                    shreg_r <= shreg_r;
                end else begin
                    shreg_r <= shreg_r << 1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_source.sv
// tb_serial_frame_source
//   Scoreboard bench for serial_frame_source. A frame-level reference model
//   tracks how many bits of the current frame remain; on each accepted word
//   it queues the expected bit stream. A monitor on the falling edge pops and
//   compares every presented bit, and checks din_ready and frames each cycle.
//   Build with +define+SERIAL_FRAME_PARITY_EN to exercise the parity variant.

module tb_serial_frame_source;

    localparam int W = 8;
`ifdef SERIAL_FRAME_PARITY_EN
    localparam int FL  = W + 1;
    localparam bit PEN = 1'b1;
`else
    localparam int FL  = W;
    localparam bit PEN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic         x;
    logic         x_valid;
    logic         x_last;
    logic [7:0]   frames;

    typedef struct packed {
        logic b;
        logic last;
    } ent_t;

    ent_t       exp_q[$];
    int         rem = 0;
    logic [7:0] frames_m = 8'd0;
    int         n_chk = 0;
    int         n_fail = 0;

    serial_frame_source #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .x         (x),
        .x_valid   (x_valid),
        .x_last    (x_last),
        .frames    (frames)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame occupies FL bit-times; a new word is taken when
    // nothing is in flight or the last bit is being presented.
    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                exp_q.delete();
                rem      = 0;
                frames_m = 8'd0;
            end else begin
                logic rdy;
                rdy = (rem <= 1);
                if (rem == 1) frames_m = frames_m + 8'd1;
                if (din_valid && rdy) begin
                    for (int i = W - 1; i >= 0; i--)
                        exp_q.push_back('{b: din[i], last: (i == 0) && !PEN});
                    if (PEN) exp_q.push_back('{b: ^din, last: 1'b1});
                    rem = FL;
                end else if (rem > 0) begin
                    rem = rem - 1;
                end
            end
        end
    end

    // Monitor: compare the presented stream against the scoreboard queue.
    initial begin
        forever begin
            @(negedge clk);
            chk("din_ready", {15'd0, din_ready}, {15'd0, (rem <= 1)});
            chk("frames", {8'd0, frames}, {8'd0, frames_m});
            if (x_valid) begin
                chk("bit_expected", {15'd0, (exp_q.size() != 0)}, 16'd1);
                if (exp_q.size() != 0) begin
                    ent_t e;
                    e = exp_q.pop_front();
                    chk("x", {15'd0, x}, {15'd0, e.b});
                    chk("x_last", {15'd0, x_last}, {15'd0, e.last});
                end
            end else begin
                chk("idle_x", {14'd0, x, x_last}, 16'd0);
                chk("no_gap", {15'd0, (exp_q.size() == 0)}, 16'd1);
            end
        end
    end

    // Offer a word and hold it until the model says it is taken.
    task automatic send(input logic [W-1:0] w);
        int guard;
        guard     = 0;
        din       = w;
        din_valid = 1'b1;
        while (!(rem <= 1) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("send_timeout", {15'd0, (guard < 100)}, 16'd1);
        @(posedge clk);
        @(negedge clk);
        din_valid = 1'b0;
        din       = W'($urandom);
    endtask

    // Wait until every queued bit has been seen and the count has settled.
    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_timeout", {15'd0, (guard < 400)}, 16'd1);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b0;
        din_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_x_valid", {15'd0, x_valid}, 16'd0);
        chk("rst_x", {15'd0, x}, 16'd0);
        chk("rst_x_last", {15'd0, x_last}, 16'd0);
        chk("rst_din_ready", {15'd0, din_ready}, 16'd1);
        chk("rst_frames", {8'd0, frames}, 16'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Single frame
        send(8'b1101_0000);
        drain();
        chk("single_frames", {8'd0, frames}, 16'd1);

        // Back-to-back frames, valid held across the switch
        send(8'hA5);
        send(8'h3C);
        drain();
        chk("b2b_frames", {8'd0, frames}, 16'd3);

        // Parity-oriented words (ordinary frames when parity is off)
        send(8'hA5);
        drain();
        send(8'h07);
        drain();
        chk("par_frames", {8'd0, frames}, 16'd5);

        // Busy offer ignored during bit 4
        send(8'h00);
        repeat (3) @(negedge clk);
        din       = 8'hFF;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        chk("busy_x_valid", {15'd0, x_valid}, 16'd0);
        chk("busy_frames", {8'd0, frames}, 16'd6);

        // Reset mid-frame during bit 3
        send(8'hC3);
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_x_valid", {15'd0, x_valid}, 16'd0);
        chk("mid_rst_x", {15'd0, x}, 16'd0);
        chk("mid_rst_din_ready", {15'd0, din_ready}, 16'd1);
        chk("mid_rst_frames", {8'd0, frames}, 16'd0);
        @(negedge clk);
        reset = 1'b1;
        send(8'h81);
        drain();
        chk("post_rst_frames", {8'd0, frames}, 16'd1);

        // Randomized traffic with random gaps (gap 0 keeps frames contiguous)
        for (int n = 0; n < 150; n++) begin
            int gap;
            send(W'($urandom));
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                din = W'($urandom);
                @(negedge clk);
            end
        end
        drain();

        // Counter wrap
        do_reset();
        for (int n = 0; n < 255; n++) send(W'($urandom));
        drain();
        chk("wrap_255", {8'd0, frames}, 16'd255);
        send(W'($urandom));
        drain();
        chk("wrap_0", {8'd0, frames}, 16'd0);
        chk("queue_empty", {15'd0, (exp_q.size() == 0)}, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
